// File: rtl/exp2_pkg.sv
// Shared constants and the 2^(i/16) knot table for the softmax exp2 datapath.
// Table entries are unsigned Q2.13, so 1.0 = 8192 and 2.0 = 16384.
package exp2_pkg;

    localparam int FRAC_W = 13;
    localparam int BASE_W = 15;

    localparam logic [BASE_W-1:0] EXP2_BASE [0:16] = '{
        15'd8192,  15'd8555,  15'd8933,  15'd9329,  15'd9742,  15'd10173,
        15'd10624, 15'd11094, 15'd11585, 15'd12098, 15'd12634, 15'd13193,
        15'd13777, 15'd14387, 15'd15024, 15'd15689, 15'd16384
    };

    // Knot k of a 2^seg_log2-segment table sits at stride 16/2^seg_log2 in EXP2_BASE.
    function automatic logic [BASE_W-1:0] exp2_base(input int unsigned k,
                                                    input int unsigned seg_log2);
        int unsigned idx;
        idx = k << (4 - seg_log2);
        if (idx > 16) idx = 16;
        return EXP2_BASE[idx];
    endfunction

endpackage

// File: rtl/exp2_interp.sv
// Secant interpolation of 2^f on one segment: registered knot fetch and slope
// product, followed by the combinational add that forms the 15-bit mantissa m.
module exp2_interp
    import exp2_pkg::*;
#(
    parameter  int SEG_LOG2 = 2,
    localparam int K_W      = (SEG_LOG2 == 0) ? 1 : SEG_LOG2,
    localparam int D_W      = FRAC_W - SEG_LOG2
) (
    input  logic              clk,
    input  logic              en,
    input  logic [K_W-1:0]    k,
    input  logic [D_W-1:0]    d,
    output logic [BASE_W-1:0] m
);

    localparam int P_W = BASE_W + D_W;

    function automatic logic [P_W-1:0] mul_fast(input logic [BASE_W-1:0] a,
                                                input logic [D_W-1:0]    b);
        return P_W'(a) * P_W'(b);
    endfunction

    logic [BASE_W-1:0] base_lo;
    logic [BASE_W-1:0] base_hi;
    logic [BASE_W-1:0] slope;
    logic [BASE_W-1:0] base_p1;
    logic [P_W-1:0]    prod_p1;

    always_comb begin
        base_lo = exp2_base(32'(k), SEG_LOG2);
        base_hi = exp2_base(32'(k) + 32'd1, SEG_LOG2);
        slope   = base_hi - base_lo;
    end

    // ---- S2 boundary: knot and slope*d product ----
    always_ff @(posedge clk) begin
        if (en) begin
            base_p1 <= base_lo;
            prod_p1 <= mul_fast(slope, d);
        end
    end

    // d spans one segment, so dividing by the segment width lands back in Q.13
    assign m = base_p1 + BASE_W'(prod_p1 >> D_W);

endmodule

// File: rtl/exp2_pipe.sv
// Three-stage 2^x evaluator for x <= 0 with valid/ready handshake and tag sideband.
// Build option EXP2_ROUND_EN: round-half-up on the final right shift instead of truncation.
module exp2_pipe
    import exp2_pkg::*;
#(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 16,
    parameter int SEG_LOG2 = 2,
    parameter int TAG_W    = 4
) (
    input  logic                   I_CLK,
    input  logic                   I_RST_N,
    input  logic                   I_VALID,
    output logic                   O_READY,
    input  logic signed [IN_W-1:0] I_X,
    input  logic [TAG_W-1:0]       I_TAG,
    output logic                   O_VALID,
    input  logic                   I_READY,
    output logic [OUT_W-1:0]       O_Y,
    output logic [TAG_W-1:0]       O_TAG,
    output logic                   O_OVF
);

    localparam int K_W = (SEG_LOG2 == 0) ? 1 : SEG_LOG2;
    localparam int D_W = FRAC_W - SEG_LOG2;
    localparam int N_W = $clog2(OUT_W + 1);
    localparam logic signed [IN_W:0] OUT_W_S = (IN_W + 1)'(OUT_W);

    // Right-shift amount from the integer part of x; anything past OUT_W flushes to zero.
    function automatic logic [N_W-1:0] sat_shift_amt(input logic signed [IN_W-1:0] x);
        logic signed [IN_W-1:0] ip;
        logic signed [IN_W:0]   neg;
        ip  = x >>> FRAC_W;
        neg = -((IN_W + 1)'(ip));
        if (!ip[IN_W-1]) return '0;
        if (neg >= OUT_W_S) return N_W'(OUT_W);
        return N_W'(neg);
    endfunction

`ifdef EXP2_ROUND_EN
    function automatic logic [OUT_W-1:0] shift_out(input logic [BASE_W-1:0] m,
                                                   input logic [N_W-1:0]    n);
        logic [OUT_W:0] acc;
        acc = (OUT_W + 1)'(m);
        if (n >= N_W'(OUT_W)) return '0;
        if (n != '0) acc = (acc + ((OUT_W + 1)'(1) << (n - 1'b1))) >> n;
        if (acc[OUT_W]) return '1;
        return acc[OUT_W-1:0];
    endfunction
`else
    function automatic logic [OUT_W-1:0] shift_out(input logic [BASE_W-1:0] m,
                                                   input logic [N_W-1:0]    n);
        if (n >= N_W'(OUT_W)) return '0;
        return OUT_W'(m) >> n;
    endfunction
`endif

    logic                 en;
    logic [K_W-1:0]       k_s1;
    logic [D_W-1:0]       d_s1;
    logic                 ovf_s1;

    logic                 vld_p0;
    logic [N_W-1:0]       n_p0;
    logic [K_W-1:0]       k_p0;
    logic [D_W-1:0]       d_p0;
    logic                 ovf_p0;
    logic [TAG_W-1:0]     tag_p0;

    logic                 vld_p1;
    logic [N_W-1:0]       n_p1;
    logic                 ovf_p1;
    logic [TAG_W-1:0]     tag_p1;
    logic [BASE_W-1:0]    m_p1;

    // The whole pipe moves in lockstep; a stalled output freezes every stage.
    assign en      = ~O_VALID | I_READY;
    assign O_READY = en;

    generate
        if (SEG_LOG2 == 0) begin : g_k_single
            assign k_s1 = '0;
        end else begin : g_k_multi
            assign k_s1 = I_X[FRAC_W-1 -: SEG_LOG2];
        end
    endgenerate

    assign d_s1   = I_X[D_W-1:0];
    assign ovf_s1 = !I_X[IN_W-1] && (I_X != '0);

    // ---- S1 boundary: split x into shift, segment and offset ----
    always_ff @(posedge I_CLK) begin
        if (!I_RST_N) begin
            vld_p0 <= 1'b0;
        end else if (en) begin
            vld_p0 <= I_VALID;
        end
    end

    always_ff @(posedge I_CLK) begin
        if (en) begin
            n_p0   <= sat_shift_amt(I_X);
            k_p0   <= k_s1;
            d_p0   <= d_s1;
            ovf_p0 <= ovf_s1;
            tag_p0 <= I_TAG;
        end
    end

    // ---- S2 boundary: interpolation product (inside exp2_interp) ----
    exp2_interp #(
        .SEG_LOG2 (SEG_LOG2)
    ) u_interp (
        .clk (I_CLK),
        .en  (en),
        .k   (k_p0),
        .d   (d_p0),
        .m   (m_p1)
    );

    always_ff @(posedge I_CLK) begin
        if (!I_RST_N) begin
            vld_p1 <= 1'b0;
        end else if (en) begin
            vld_p1 <= vld_p0;
        end
    end

    always_ff @(posedge I_CLK) begin
        if (en) begin
            n_p1   <= n_p0;
            ovf_p1 <= ovf_p0;
            tag_p1 <= tag_p0;
        end
    end

    // ---- S3 boundary: shift by integer part, saturate positive inputs ----
    always_ff @(posedge I_CLK) begin
        if (!I_RST_N) begin
            O_VALID <= 1'b0;
            O_Y     <= '0;
            O_TAG   <= '0;
            O_OVF   <= 1'b0;
        end else if (en) begin
            O_VALID <= vld_p1;
            O_Y     <= ovf_p1 ? '1 : shift_out(m_p1, n_p1);
            O_TAG   <= tag_p1;
            O_OVF   <= ovf_p1;
        end
    end

endmodule

// File: tb/tb_exp2_pipe.sv
// Scoreboard bench for exp2_pipe: directed known points, backpressure, mid-stream
// reset and randomized inputs checked against an arithmetic 2^x reference.
module tb_exp2_pipe;

    localparam int IN_W     = 24;
    localparam int OUT_W    = 16;
    localparam int SEG_LOG2 = 2;
    localparam int TAG_W    = 4;

    logic              I_CLK   = 1'b0;
    logic              I_RST_N = 1'b0;
    logic              I_VALID = 1'b0;
    logic              I_READY = 1'b1;
    logic [IN_W-1:0]   I_X     = '0;
    logic [TAG_W-1:0]  I_TAG   = '0;
    logic              O_READY;
    logic              O_VALID;
    logic [OUT_W-1:0]  O_Y;
    logic [TAG_W-1:0]  O_TAG;
    logic              O_OVF;

    exp2_pipe #(
        .IN_W     (IN_W),
        .OUT_W    (OUT_W),
        .SEG_LOG2 (SEG_LOG2),
        .TAG_W    (TAG_W)
    ) dut (
        .I_CLK   (I_CLK),
        .I_RST_N (I_RST_N),
        .I_VALID (I_VALID),
        .O_READY (O_READY),
        .I_X     (I_X),
        .I_TAG   (I_TAG),
        .O_VALID (O_VALID),
        .I_READY (I_READY),
        .O_Y     (O_Y),
        .O_TAG   (O_TAG),
        .O_OVF   (O_OVF)
    );

    initial forever #5 I_CLK = ~I_CLK;

    int TBL [0:16] = '{8192, 8555, 8933, 9329, 9742, 10173, 10624, 11094, 11585,
                       12098, 12634, 13193, 13777, 14387, 15024, 15689, 16384};

    typedef struct {
        int y;
        int tag;
        int ovf;
        int acc;
        bit lat;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   rdy_mode = 0;
    bit   mon_en   = 1'b0;

    always @(posedge I_CLK) cyc = cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // 2^x from first principles: floor split, secant through the table knots, shift.
    function automatic exp_t model(input int x, input int tag);
        exp_t e;
        int ip, n, f, s, st, k, d, b0, b1, m;
        e.tag = tag;
        e.acc = 0;
        e.lat = 1'b0;
        if (x > 0) begin
            e.y   = (1 << OUT_W) - 1;
            e.ovf = 1;
            return e;
        end
        e.ovf = 0;
        ip = -((-x + 8191) / 8192);
        n  = -ip;
        f  = x - ip * 8192;
        s  = 8192 >> SEG_LOG2;
        st = 16 >> SEG_LOG2;
        k  = f / s;
        d  = f % s;
        b0 = TBL[k * st];
        b1 = TBL[(k + 1) * st];
        m  = b0 + ((b1 - b0) * d) / s;
        if (n >= OUT_W) begin
            e.y = 0;
        end else begin
`ifdef EXP2_ROUND_EN
            if (n == 0) e.y = m;
            else        e.y = (m + (1 << (n - 1))) >> n;
            if (e.y > (1 << OUT_W) - 1) e.y = (1 << OUT_W) - 1;
`else
            e.y = m >> n;
`endif
        end
        return e;
    endfunction

    function automatic logic rdy_now();
        case (rdy_mode)
            0:       return 1'b1;
            1:       return (cyc % 3) == 0;
            2:       return $urandom_range(0, 3) != 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic idle(input int nc);
        repeat (nc) begin
            @(negedge I_CLK);
            I_VALID = 1'b0;
            I_READY = rdy_now();
        end
    endtask

    task automatic send(input int x, input int tag, input bit lat);
        exp_t e;
        bit   done;
        done  = 1'b0;
        e     = model(x, tag);
        e.lat = lat;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge I_CLK);
            I_VALID = 1'b1;
            I_X     = x[IN_W-1:0];
            I_TAG   = tag[TAG_W-1:0];
            I_READY = rdy_now();
            #1;
            if (O_READY === 1'b1) begin
                e.acc = cyc;
                sb.push_back(e);
                done = 1'b1;
            end
        end
        if (!done) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    // Output monitor: handshake rule, hold-while-stalled, and in-order scoreboard pop.
    exp_t             me;
    bit               prev_stall = 1'b0;
    logic [OUT_W-1:0] prev_y;
    logic [TAG_W-1:0] prev_tag;
    logic             prev_ovf;

    always @(negedge I_CLK) begin
        #2;
        if (!mon_en || I_RST_N !== 1'b1) begin
            prev_stall = 1'b0;
        end else begin
            chk("o_ready", O_READY, (!O_VALID || I_READY));
            if (prev_stall) begin
                chk("hold_valid", O_VALID, 1);
                chk("hold_y", O_Y, prev_y);
                chk("hold_tag", O_TAG, prev_tag);
                chk("hold_ovf", O_OVF, prev_ovf);
            end
            if (O_VALID === 1'b1 && I_READY === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("spurious_valid", O_VALID, 0);
                end else begin
                    me = sb.pop_front();
                    chk("y", O_Y, me.y);
                    chk("tag", O_TAG, me.tag);
                    chk("ovf", O_OVF, me.ovf);
                    if (me.lat) chk("latency", cyc - me.acc, 3);
                end
            end
            prev_stall = (O_VALID === 1'b1) && (I_READY === 1'b0);
            prev_y     = O_Y;
            prev_tag   = O_TAG;
            prev_ovf   = O_OVF;
        end
    end

    initial begin
        int x, r;

        // Reset held with a valid input present
        I_RST_N = 1'b0;
        I_VALID = 1'b1;
        I_READY = 1'b1;
        repeat (2) @(posedge I_CLK);
        #2;
        chk("rst_valid", O_VALID, 0);
        chk("rst_y", O_Y, 0);
        chk("rst_ovf", O_OVF, 0);
        chk("rst_tag", O_TAG, 0);
        I_RST_N  = 1'b1;
        mon_en   = 1'b1;
        rdy_mode = 0;

        // Known points, back-to-back, latency checked
        send(0, 1, 1);
        send(-8192, 2, 1);
        send(-4096, 3, 1);
        send(-6144, 10, 1);
        send(-16 * 8192, 4, 1);
        send(1, 5, 1);
        send(-(1 << (IN_W - 1)), 6, 1);
        send(-1, 7, 1);
        send(-12 * 8192, 8, 1);
        send(-15 * 8192 - 1, 9, 1);
        send(-3 * 8192 + 1000, 11, 1);
        send(8191, 12, 1);
        idle(6);

        // Backpressure with I_READY 1,0,0 repeating
        rdy_mode = 1;
        for (int i = 0; i < 8; i++) send(-int'($urandom_range(0, 5 * 8192)), i, 1'b0);
        idle(24);

        // Randomized stream with random gaps and backpressure
        rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 6)      x = -int'($urandom_range(0, 16 * 8192));
            else if (r < 8) x = int'($urandom_range(0, (1 << IN_W) - 1)) - (1 << (IN_W - 1));
            else            x = int'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) idle(1);
            send(x, int'($urandom_range(0, 15)), 1'b0);
        end
        rdy_mode = 0;
        idle(8);

        // Reset while three samples are stalled in flight
        rdy_mode = 3;
        send(-100, 1, 1'b0);
        send(-9000, 2, 1'b0);
        send(-20000, 3, 1'b0);
        idle(3);
        @(negedge I_CLK);
        mon_en  = 1'b0;
        I_VALID = 1'b0;
        I_RST_N = 1'b0;
        @(posedge I_CLK);
        #2;
        chk("midrst_valid", O_VALID, 0);
        chk("midrst_y", O_Y, 0);
        sb.delete();
        @(negedge I_CLK);
        I_RST_N  = 1'b1;
        rdy_mode = 0;
        I_READY  = 1'b1;
        mon_en   = 1'b1;
        idle(10);
        send(-4096, 13, 1);
        send(-6144, 10, 1);
        idle(6);

        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge I_CLK);
        chk("drain_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
